// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle for uart_rx_param: holding-register data with
// valid/ready handshake, frame-in-progress indication and one-cycle error pulses.
// The receiver drives through the master modport; the consumer uses slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out, valid, busy, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  data_out, valid, busy, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits and a parity checker; without it parity_err is tied low and PARITY_ODD
// has no effect.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge while enable=1
// S_START  | start bit; mid-bit sample rejects glitches back to idle
// S_DATA   | one mid-bit sample per bit period, LSB first
// S_PARITY | single parity-bit sample (UART_RX_PARITY_EN only)
// S_STOP   | stop-bit samples; a 0 aborts the frame with frame_err
module uart_rx_param #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       in,
  uart_rx_if.master  bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_MID  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BAUD_END  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_rs;
  logic                  r_rs_d;
  logic [CW-1:0]         r_baud_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data_out;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_overrun;

  logic w_fall;
  logic w_baud_mid;
  logic w_baud_end;
  logic w_baud_clr;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_adv;
  logic w_done_ok;
  logic w_done_fe;
  logic w_par_bad;
  logic w_good;
  logic w_hold_full;

  assign w_fall     = r_rs_d & ~r_rs;
  assign w_baud_mid = (r_baud_cnt == BAUD_MID);
  assign w_baud_end = (r_baud_cnt == BAUD_END);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  assign w_par_bad = r_par_bit != ((^r_shift) ^ 1'(PARITY_ODD));
`else
  logic w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0);
  assign w_par_bad    = 1'b0;
`endif

  assign w_good      = w_done_ok & ~w_par_bad;
  assign w_hold_full = r_valid & ~bus.ready;

  // Two-flop synchroniser on the pad input plus a delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rs    <= 1'b1;
      r_rs_d  <= 1'b1;
    end else begin
      r_sync1 <= in;
      r_rs    <= r_sync1;
      r_rs_d  <= r_rs;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_adv  = 1'b0;
    w_done_ok   = 1'b0;
    w_done_fe   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_fall) begin
          w_state_nxt = S_START;
          w_baud_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_mid) begin
          w_baud_clr  = 1'b1;
          w_state_nxt = r_rs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_clr = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_clr  = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_clr = 1'b1;
          if (!r_rs) begin
            w_done_fe   = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_stop_cnt == STOP_LAST) begin
            w_done_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_adv  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit-period timing and bit/stop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      if (w_baud_clr)             r_baud_cnt <= '0;
      else if (r_state != S_IDLE) r_baud_cnt <= r_baud_cnt + 1'b1;

      if (r_state == S_IDLE)      r_bit_cnt <= '0;
      else if (w_shift_en)        r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;

      if (r_state == S_IDLE)      r_stop_cnt <= 1'b0;
      else if (w_stop_adv)        r_stop_cnt <= 1'b1;
    end
  end

  // Data (and parity) capture at the mid-bit sample points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else begin
      if (w_shift_en) r_shift[r_bit_cnt] <= r_rs;
`ifdef UART_RX_PARITY_EN
      if (w_par_en) r_par_bit <= r_rs;
`endif
    end
  end

  // Holding register, handshake and one-cycle error pulses. A frame that
  // completes while the consumer is popping is loaded, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_done_fe;
      r_parity_err <= w_done_ok & w_par_bad;
      r_overrun    <= w_good & w_hold_full;
      if (w_good && !w_hold_full) begin
        r_data_out <= r_shift;
        r_valid    <= 1'b1;
      end else if (r_valid && bus.ready) begin
        r_valid    <= 1'b0;
      end
    end
  end

  // w_par_en is only consumed when the parity stage is built in.
  logic w_unused_par_en;
  assign w_unused_par_en = w_par_en;

  assign bus.data_out   = r_data_out;
  assign bus.valid      = r_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at CLK_DIV=16, 8 data bits, 1 stop bit.
// A vector table covers ordinary frames, framing errors and enable gating;
// hand-written sequences cover glitch rejection, break after frame error,
// overrun, reset mid-frame and (when built with UART_RX_PARITY_EN) parity.
module tb_uart_rx_param;

  localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic ser    = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus_if ();

  uart_rx_param #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .in     (ser),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_fe    = 0;
  int n_pe    = 0;
  int n_ov    = 0;
  logic [7:0] last_data = 8'h00;

  // Event counters sampled mid-cycle; valid&ready counts accepted bytes.
  always @(negedge clk) begin
    if (bus_if.valid && bus_if.ready) begin
      n_valid   = n_valid + 1;
      last_data = bus_if.data_out;
    end
    if (bus_if.frame_err)  n_fe = n_fe + 1;
    if (bus_if.parity_err) n_pe = n_pe + 1;
    if (bus_if.overrun)    n_ov = n_ov + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_flip);
    send_bit(stop_v);
    ser = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       en;
    logic       exp_ok;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, fe0, pe0, ov0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};

    bus_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",    bus_if.valid,      0);
    check("rst_data",     bus_if.data_out,   0);
    check("rst_busy",     bus_if.busy,       0);
    check("rst_fe",       bus_if.frame_err,  0);
    check("rst_pe",       bus_if.parity_err, 0);
    check("rst_ov",       bus_if.overrun,    0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    enable       = 1'b1;
    bus_if.ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      v0 = n_valid; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
      enable = vecs[i].en;
      send_frame(vecs[i].data, vecs[i].stop_v, 1'b0);
      enable = 1'b1;
      check("vec_valid_cnt", n_valid - v0, {31'd0, vecs[i].exp_ok});
      if (vecs[i].exp_ok) check("vec_data", last_data, vecs[i].data);
      check("vec_fe_cnt", n_fe - fe0, {31'd0, vecs[i].exp_fe});
      check("vec_pe_cnt", n_pe - pe0, 0);
      check("vec_ov_cnt", n_ov - ov0, 0);
      check("vec_busy_end", bus_if.busy, 0);
    end

    // Short low pulse: rejected at the mid-start sample.
    v0 = n_valid; fe0 = n_fe;
    ser = 1'b0;
    repeat (4) @(negedge clk);
    ser = 1'b1;
    @(negedge clk);
    check("glitch_busy_up", bus_if.busy, 1);
    repeat (20) @(negedge clk);
    check("glitch_busy_down", bus_if.busy, 0);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_no_fe", n_fe - fe0, 0);

    // Break: line held low through and past the stop bit.
    fe0 = n_fe; v0 = n_valid;
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    repeat (3 * CLK_DIV) @(negedge clk);
    check("break_fe_once", n_fe - fe0, 1);
    check("break_not_redetected", bus_if.busy, 0);
    ser = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("break_no_valid", n_valid - v0, 0);

    // Overrun: consumer stalled across two frames.
    bus_if.ready = 1'b0;
    ov0 = n_ov;
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_first_valid", bus_if.valid, 1);
    check("ovr_first_data", bus_if.data_out, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_pulse", n_ov - ov0, 1);
    check("ovr_data_kept", bus_if.data_out, 8'h11);
    check("ovr_valid_held", bus_if.valid, 1);
    bus_if.ready = 1'b1;
    @(negedge clk);
    check("ovr_pop_valid", bus_if.valid, 0);

    // Reset in the middle of data bit 3 of 0xFF with a byte held.
    bus_if.ready = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0);
    check("rst_pre_valid", bus_if.valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ser = 1'b1;
    repeat (CLK_DIV / 2) @(negedge clk);
    check("rst_pre_busy", bus_if.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus_if.valid, 0);
    check("arst_data", bus_if.data_out, 0);
    check("arst_busy", bus_if.busy, 0);
    check("arst_flags", {bus_if.frame_err, bus_if.parity_err, bus_if.overrun}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6 * CLK_DIV) @(negedge clk);
    bus_if.ready = 1'b1;
    v0 = n_valid;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_rst_valid_cnt", n_valid - v0, 1);
    check("post_rst_data", last_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_bad_pulse", n_pe - pe0, 1);
    check("par_bad_no_valid", n_valid - v0, 0);
    v0 = n_valid; pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_ok_no_pulse", n_pe - pe0, 0);
    check("par_ok_valid", n_valid - v0, 1);
    check("par_ok_data", last_data, 8'h07);
`else
    check("no_parity_pulses", n_pe, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
